freq_bram_refresh_ctrl: RTL and testbench

Sequences the periodic copy of SDFT frequency bins into the single-port frequency BRAM that the VGA waterfall reader also uses. Every REFRESH_BRAM_CYCLES video frames it walks all bins, reads real and imaginary parts, and computes a saturated |re|+|im| magnitude. It writes each magnitude into the BRAM, yielding every cycle the video reader requests the port. It advances the waterfall row pointer once per completed copy.

---
 rtl/freq_bram_refresh_ctrl_pkg.sv | 25 ++
 rtl/freq_bram_refresh_ctrl_if.sv | 26 ++
 rtl/freq_bram_refresh_ctrl_mag.sv | 29 ++
 rtl/freq_bram_refresh_ctrl.sv | 162 ++++++++++++++++
 tb/tb_freq_bram_refresh_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_bram_refresh_ctrl_pkg.sv
// Shared types and helpers for the frequency-BRAM refresh controller:
// the copy FSM state encoding, width derivation and magnitude saturation.
package freq_bram_refresh_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int width_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Clamp val to the largest value representable in out_w unsigned bits.
  function automatic logic [31:0] sat_mag(input logic [31:0] val, input int out_w);
    logic [32:0] lim;
    lim = 33'(1) << out_w;
    if ({1'b0, val} >= lim) return 32'(lim - 33'd1);
    return val;
  endfunction

endpackage

// File: rtl/freq_bram_refresh_ctrl_if.sv
// Bin-read and BRAM-write port bundle of the refresh controller; the
// controller is the master, the SDFT bin store / BRAM / video side the slave.
interface freq_bram_refresh_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8
);
  logic                     bin_rd;
  logic [ADDR_W-1:0]        bin_addr;
  logic signed [DATA_W-1:0] bin_real;
  logic signed [DATA_W-1:0] bin_imag;
  logic                     vid_req;
  logic                     ram_we;
  logic [ADDR_W-1:0]        ram_addr;
  logic [OUT_W-1:0]         ram_wdata;

  modport master (
    output bin_rd, bin_addr, ram_we, ram_addr, ram_wdata,
    input  bin_real, bin_imag, vid_req
  );

  modport slave (
    input  bin_rd, bin_addr, ram_we, ram_addr, ram_wdata,
    output bin_real, bin_imag, vid_req
  );
endinterface

// File: rtl/freq_bram_refresh_ctrl_mag.sv
// Combinational |re|+|im| magnitude: absolute values in DATA_W unsigned bits,
// DATA_W+1 bit sum, right shift by MAG_SHIFT, then saturation to OUT_W bits.
module freq_mag_sat
  import freq_bram_refresh_ctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 8,
  parameter int MAG_SHIFT = 4
) (
  input  logic signed [DATA_W-1:0] re_i,
  input  logic signed [DATA_W-1:0] im_i,
  output logic [OUT_W-1:0]         mag_o
);

  logic [DATA_W-1:0] abs_re;
  logic [DATA_W-1:0] abs_im;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted;

  always_comb begin
    // The most negative input wraps to 2^(DATA_W-1), which is exactly its magnitude.
    abs_re  = re_i[DATA_W-1] ? DATA_W'(-re_i) : DATA_W'(re_i);
    abs_im  = im_i[DATA_W-1] ? DATA_W'(-im_i) : DATA_W'(im_i);
    sum     = {1'b0, abs_re} + {1'b0, abs_im};
    shifted = sum >> MAG_SHIFT;
    mag_o   = OUT_W'(sat_mag(32'(shifted), OUT_W));
  end

endmodule

// File: rtl/freq_bram_refresh_ctrl.sv
// Periodically copies SDFT bin magnitudes into the shared frequency BRAM,
// yielding the port to the video reader. Optional REFRESH_OVERRUN_CNT_EN adds
// a saturating count of refresh requests that arrived while one was outstanding.
module freq_bram_refresh_ctrl
  import freq_bram_refresh_ctrl_pkg::*;
#(
  parameter int  FREQ_BINS           = 320,
  parameter int  REFRESH_BRAM_CYCLES = 20,
  parameter int  ROWS                = 240,
  parameter int  DATA_W              = 16,
  parameter int  OUT_W               = 8,
  parameter int  MAG_SHIFT           = 4,
  localparam int ADDR_W              = width_for(FREQ_BINS),
  localparam int ROW_W               = width_for(ROWS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        vsync_pulse,
  input  logic                        sdft_busy,
  freq_bram_refresh_ctrl_if.master    bus,
  output logic                        busy,
  output logic [ROW_W-1:0]            row_ptr,
  output logic [7:0]                  overrun_cnt
);

  localparam int FC_W = width_for(REFRESH_BRAM_CYCLES);
  localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(REFRESH_BRAM_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BIN_LAST = ADDR_W'(FREQ_BINS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [OUT_W-1:0]  mag_q, mag_d, mag_w;
  logic              busy_q, busy_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic              pending_q, pending_d;
  logic              refresh_evt;
  logic              start;
  logic              bin_rd;
  logic              ram_we;

  freq_mag_sat #(
    .DATA_W   (DATA_W),
    .OUT_W    (OUT_W),
    .MAG_SHIFT(MAG_SHIFT)
  ) u_mag (
    .re_i (bus.bin_real),
    .im_i (bus.bin_imag),
    .mag_o(mag_w)
  );

  // Frame counting and the single-deep refresh request; a new request wins
  // over the clear issued when a copy starts.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    fc_d        = fc_q;
    refresh_evt = 1'b0;
    if (vsync_pulse) begin
      if (fc_q == FC_LAST) begin
        fc_d        = '0;
        refresh_evt = 1'b1;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
    pending_d = refresh_evt ? 1'b1 : (start ? 1'b0 : pending_q);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mag_d   = mag_q;
    busy_d  = busy_q;
    row_d   = row_q;
    start   = 1'b0;
    bin_rd  = 1'b0;
    ram_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q && !sdft_busy) begin
          state_d = ST_RD;
          start   = 1'b1;
          busy_d  = 1'b1;
          k_d     = '0;
        end
      end
      ST_RD: begin
        bin_rd  = 1'b1;
        state_d = ST_CAP;
      end
      ST_CAP: begin
        mag_d   = mag_w;
        state_d = ST_WR;
      end
      ST_WR: begin
        // The video reader owns the port whenever it asks; hold mag until it lets go.
        if (!bus.vid_req) begin
          ram_we = 1'b1;
          if (k_q == BIN_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      mag_q     <= '0;
      busy_q    <= 1'b0;
      row_q     <= '0;
      fc_q      <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      mag_q     <= mag_d;
      busy_q    <= busy_d;
      row_q     <= row_d;
      fc_q      <= fc_d;
      pending_q <= pending_d;
    end
  end

`ifdef REFRESH_OVERRUN_CNT_EN
  logic       overrun;
  logic [7:0] ovr_q;

  assign overrun = refresh_evt && (pending_q || busy_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q <= '0;
    end else if (overrun && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = '0;
`endif

  assign bus.bin_rd    = bin_rd;
  assign bus.bin_addr  = k_q;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = k_q;
  assign bus.ram_wdata = mag_q;
  assign busy          = busy_q;
  assign row_ptr       = row_q;

endmodule

// File: tb/tb_freq_bram_refresh_ctrl.sv
// Scoreboard bench for freq_bram_refresh_ctrl: copies are requested with vsync
// pulses, expected BRAM writes/rows/durations are queued from a magnitude model.
module tb_freq_bram_refresh_ctrl;

  localparam int FB = 4;
  localparam int RC = 2;
  localparam int RW = 3;
  localparam int DW = 16;
  localparam int OW = 8;
  localparam int MS = 0;
  localparam int AW = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vsync_pulse;
  logic       sdft_busy;
  logic       busy;
  logic [1:0] row_ptr;
  logic [7:0] overrun_cnt;

  freq_bram_refresh_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .OUT_W(OW)) bus ();

  freq_bram_refresh_ctrl #(
    .FREQ_BINS          (FB),
    .REFRESH_BRAM_CYCLES(RC),
    .ROWS               (RW),
    .DATA_W             (DW),
    .OUT_W              (OW),
    .MAG_SHIFT          (MS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vsync_pulse(vsync_pulse),
    .sdft_busy  (sdft_busy),
    .bus        (bus),
    .busy       (busy),
    .row_ptr    (row_ptr),
    .overrun_cnt(overrun_cnt)
  );

  // Stand-alone magnitude block with a non-zero shift.
  logic signed [DW-1:0] m_re, m_im;
  logic [OW-1:0]        m_out;
  freq_mag_sat #(.DATA_W(DW), .OUT_W(OW), .MAG_SHIFT(4)) u_mag4 (
    .re_i(m_re), .im_i(m_im), .mag_o(m_out)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;

  int  tests = 0;
  int  fails = 0;
  int  re_mem[FB];
  int  im_mem[FB];
  wr_t exp_wr_q[$];
  int  exp_dur_q[$];
  int  exp_row_q[$];
  int  row_model;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference magnitude straight from the arithmetic rules.
  function automatic int model_mag(input int re, input int im, input int sh, input int ow);
    int s;
    s = (re < 0 ? -re : re) + (im < 0 ? -im : im);
    s = s >> sh;
    if (s > (1 << ow) - 1) s = (1 << ow) - 1;
    return s;
  endfunction

  function automatic int rand_val();
    case ($urandom_range(0, 5))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic rand_mems();
    for (int k = 0; k < FB; k++) begin
      re_mem[k] = rand_val();
      im_mem[k] = rand_val();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    vsync_pulse = 1'b1;
    step();
    vsync_pulse = 1'b0;
  endtask

  // dur < 0 means the copy length depends on random stalls and is not checked.
  task automatic expect_copy(input int dur);
    for (int k = 0; k < FB; k++) begin
      wr_t w;
      w.addr = k;
      w.data = model_mag(re_mem[k], im_mem[k], MS, OW);
      exp_wr_q.push_back(w);
    end
    row_model = (row_model + 1) % RW;
    exp_row_q.push_back(row_model);
    exp_dur_q.push_back(dur);
  endtask

  task automatic wait_busy(input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (busy !== val && n < budget) begin
      step();
      n++;
    end
    if (busy !== val) fail_now(name);
  endtask

  // Bin store: returns the addressed bin the cycle after bin_rd.
  int rsp_addr;
  initial begin
    bus.bin_real = '0;
    bus.bin_imag = '0;
    forever begin
      @(posedge clk);
      if (reset_n && bus.bin_rd) begin
        rsp_addr = int'(bus.bin_addr);
        #1;
        bus.bin_real = DW'(re_mem[rsp_addr]);
        bus.bin_imag = DW'(im_mem[rsp_addr]);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT writes or finishes a copy.
  int  run_cnt = 0;
  bit  in_copy = 1'b0;
  wr_t mon_w;
  int  mon_d, mon_r;
  always @(negedge clk) begin
    if (!reset_n) begin
      in_copy = 1'b0;
      run_cnt = 0;
    end else begin
      if (bus.ram_we) begin
        check("we_with_vid_req", bus.vid_req, 0);
        if (exp_wr_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          mon_w = exp_wr_q.pop_front();
          check("ram_addr", bus.ram_addr, mon_w.addr);
          check("ram_wdata", bus.ram_wdata, mon_w.data);
        end
      end
      if (busy) begin
        in_copy = 1'b1;
        run_cnt++;
      end else if (in_copy) begin
        in_copy = 1'b0;
        if (exp_dur_q.size() == 0 || exp_row_q.size() == 0) begin
          fail_now("unexpected_copy_end");
        end else begin
          mon_d = exp_dur_q.pop_front();
          mon_r = exp_row_q.pop_front();
          if (mon_d >= 0) check("copy_cycles", run_cnt, mon_d);
          check("row_ptr", row_ptr, mon_r);
        end
        run_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  int exp_ovr;

  initial begin
    reset_n     = 1'b0;
    vsync_pulse = 1'b0;
    sdft_busy   = 1'b0;
    bus.vid_req = 1'b0;
    row_model   = 0;
    m_re        = '0;
    m_im        = '0;

    // Magnitude block with shift 4.
    m_re = 16'sd100; m_im = 16'sd60; #1;
    check("mag_shift4_100_60", m_out, model_mag(100, 60, 4, OW));
    for (int i = 0; i < 6; i++) begin
      int a, b;
      a = rand_val(); b = rand_val();
      m_re = DW'(a); m_im = DW'(b); #1;
      check("mag_shift4_rand", m_out, model_mag(a, b, 4, OW));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_row_ptr", row_ptr, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_bin_rd", bus.bin_rd, 0);
    check("rst_ram_wdata", bus.ram_wdata, 0);
    check("rst_overrun_cnt", overrun_cnt, 0);
    reset_n = 1'b1;
    step();

    // Directed magnitudes, unstalled copy of 12 cycles.
    re_mem = '{-3, -32768, 100, 5};
    im_mem = '{4, 0, 60, -7};
    expect_copy(12);
    pulse(); step(); step(); pulse();
    check("busy_before_start", busy, 0);
    step();
    check("busy_rise", busy, 1);
    wait_busy(1'b0, 40, "copy1_timeout");
    step();

    // Five-cycle video stall during WR of bin 2.
    rand_mems();
    expect_copy(17);
    pulse(); step(); pulse(); step();
    check("stall_busy_rise", busy, 1);
    repeat (8) step();
    bus.vid_req = 1'b1;
    repeat (5) step();
    bus.vid_req = 1'b0;
    wait_busy(1'b0, 40, "stall_copy_timeout");
    step();

    // sdft_busy holds off the start; ignored once the copy runs.
    rand_mems();
    expect_copy(12);
    sdft_busy = 1'b1;
    pulse(); step(); pulse();
    repeat (5) step();
    check("busy_held_by_sdft", busy, 0);
    sdft_busy = 1'b0;
    step();
    check("start_after_sdft", busy, 1);
    sdft_busy = 1'b1;
    wait_busy(1'b0, 40, "sdft_copy_timeout");
    sdft_busy = 1'b0;
    step();

    // Two requests during a long stall: one extra copy, two overruns.
    rand_mems();
    expect_copy(-1);
    expect_copy(12);
    pulse(); step(); pulse(); step();
    bus.vid_req = 1'b1;
    repeat (4) begin
      pulse();
      step();
    end
    bus.vid_req = 1'b0;
    wait_busy(1'b0, 60, "overrun_copy_timeout");
    step();
    check("requeued_copy", busy, 1);
    wait_busy(1'b0, 40, "requeued_copy_timeout");
    repeat (5) step();
    check("no_second_requeue", busy, 0);
`ifdef REFRESH_OVERRUN_CNT_EN
    exp_ovr = 2;
`else
    exp_ovr = 0;
`endif
    check("overrun_cnt", overrun_cnt, exp_ovr);

    // Random bins with random video contention.
    for (int i = 0; i < 6; i++) begin
      rand_mems();
      expect_copy(-1);
      pulse(); step(); pulse();
      wait_busy(1'b1, 5, "rand_start_timeout");
      for (int c = 0; c < 400 && busy; c++) begin
        bus.vid_req = ($urandom_range(0, 3) == 0);
        step();
      end
      bus.vid_req = 1'b0;
      wait_busy(1'b0, 40, "rand_copy_timeout");
      repeat ($urandom_range(1, 4)) step();
    end

    // Reset in the middle of a write cycle.
    rand_mems();
    pulse(); step(); pulse(); step(); step(); step();
    check("we_before_reset", bus.ram_we, 1);
    #1;
    reset_n = 1'b0;
    exp_wr_q.delete();
    exp_dur_q.delete();
    exp_row_q.delete();
    row_model = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ram_we", bus.ram_we, 0);
    check("midrst_row_ptr", row_ptr, 0);
    check("midrst_overrun_cnt", overrun_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();

    // Normal copy after reset.
    rand_mems();
    expect_copy(12);
    pulse(); step(); pulse();
    wait_busy(1'b1, 5, "post_rst_start_timeout");
    wait_busy(1'b0, 40, "post_rst_copy_timeout");
    repeat (3) step();

    check("leftover_writes", exp_wr_q.size(), 0);
    check("leftover_copies", exp_dur_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
